// File: rtl/logic_pkg.sv
// -----------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the pipelined bitwise logic unit.
//   lu_op_t  : 3-bit opcode enumeration (all eight codes are defined)
//   lu_eval  : single-bit evaluation of an opcode; callers apply it across
//              their own WIDTH, so the package stays width-agnostic.
// -----------------------------------------------------------------------------
package logic_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND  = 3'd0,
    LU_OR   = 3'd1,
    LU_NOT  = 3'd2,
    LU_NAND = 3'd3,
    LU_NOR  = 3'd4,
    LU_XOR  = 3'd5,
    LU_XNOR = 3'd6,
    LU_PASS = 3'd7
  } lu_op_t;

  // Bitwise ops have no carries, so evaluating one bit position at a time
  // lets any WIDTH reuse this function without width-dependent arguments.
  function automatic logic lu_eval(input lu_op_t op, input logic a, input logic b);
    logic r;
    case (op)
      LU_AND:  r = a & b;
      LU_OR:   r = a | b;
      LU_NOT:  r = ~a;
      LU_NAND: r = ~(a & b);
      LU_NOR:  r = ~(a | b);
      LU_XOR:  r = a ^ b;
      LU_XNOR: r = ~(a ^ b);
      default: r = b;  // LU_PASS
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_comb.sv
// -----------------------------------------------------------------------------
// logic_unit_comb
// Purely combinational opcode evaluation plus result flags.
// Ports:
//   op      in   lu_op_t  opcode
//   a, b    in   WIDTH    operands
//   result  out  WIDTH    bitwise result
//   zero    out  1        result == 0
//   parity  out  1        XOR-reduction of result
// -----------------------------------------------------------------------------
module logic_unit_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  lu_op_t             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               parity
);

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = lu_eval(op, a[i], b[i]);
    end
    zero   = (result == '0);
    parity = ^result;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 registers the operand beat, S2 registers the evaluated result and flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_op, in_a, in_b          opcode and operands
//   out_valid/out_ready        result handshake
//   out_result, out_op         result and the opcode that produced it
//   out_zero, out_parity       result == 0, XOR-reduction of result
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_parity
);

  localparam logic RESET_ZERO   = (RESET_DATA == '0);
  localparam logic RESET_PARITY = ^RESET_DATA;

  logic             s1_valid_q, s1_valid_d;
  lu_op_t           s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;

  logic             s2_valid_q,  s2_valid_d;
  lu_op_t           s2_op_q,     s2_op_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_zero_q,   s2_zero_d;
  logic             s2_parity_q, s2_parity_d;

  logic             s1_en, s2_en;
  logic [WIDTH-1:0] comb_result;
  logic             comb_zero, comb_parity;

  // ---- S1 -> S2 boundary: evaluation between the two register stages ----
  logic_unit_comb #(.WIDTH(WIDTH)) u_comb (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (comb_result),
    .zero   (comb_zero),
    .parity (comb_parity)
  );

  always_comb begin
    // A stage may load whenever it is empty or its contents move on, so
    // bubbles collapse even while the consumer is stalled.
    s2_en    = !s2_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;

    // ---- input -> S1 ----
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_en && in_valid) begin
      s1_op_d = lu_op_t'(in_op);
      s1_a_d  = in_a;
      s1_b_d  = in_b;
    end

    // ---- S1 -> S2 ----
    s2_valid_d  = s2_en ? s1_valid_q : s2_valid_q;
    s2_op_d     = s2_op_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_parity_d = s2_parity_q;
    if (s2_en && s1_valid_q) begin
      s2_op_d     = s1_op_q;
      s2_result_d = comb_result;
      s2_zero_d   = comb_zero;
      s2_parity_d = comb_parity;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= LU_AND;
      s1_a_q      <= RESET_DATA;
      s1_b_q      <= RESET_DATA;
      s2_valid_q  <= 1'b0;
      s2_op_q     <= LU_AND;
      s2_result_q <= RESET_DATA;
      s2_zero_q   <= RESET_ZERO;
      s2_parity_q <= RESET_PARITY;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_op_q     <= s2_op_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_parity_q <= s2_parity_d;
    end
  end

  // ---- S2 -> output ----
  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_op     = s2_op_q;
  assign out_zero   = s2_zero_q;
  assign out_parity = s2_parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Self-checking bench for logic_unit_pipe (WIDTH=8): reset, a streaming
// vector table, flag cases, backpressure, bubble collapse, mid-stream reset
// and a randomized valid/ready run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_op;
  logic         out_zero, out_parity;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .RESET_DATA('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_parity (out_parity)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         parity;
  } vec_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
  } exp_t;

  // Reference: whole-word operations straight from the opcode table.
  function automatic logic [W-1:0] ref_eval(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: inputs are driven and
  // outputs sampled there, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic chk_out(input string name, input logic [2:0] op, input logic [W-1:0] res);
    chk({name, "_valid"},  out_valid, 1);
    chk({name, "_result"}, out_result, res);
    chk({name, "_op"},     out_op, op);
    chk({name, "_zero"},   out_zero, (res == '0));
    chk({name, "_parity"}, out_parity, ^res);
  endtask

  vec_t vecs[10];
  exp_t q[$];

  initial begin
    logic [W-1:0] r1, r2, r3;
    logic [W-1:0] held_res;
    logic [2:0]   held_op;
    logic         held_z, held_p, prev_stall;
    int           accepted, cycles;
    exp_t         e;

    // Streaming table (a=0xF0, b=0x3C, ops 0..7) followed by flag cases.
    for (int i = 0; i < 8; i++) begin
      vecs[i].op = 3'(i);
      vecs[i].a  = 8'hF0;
      vecs[i].b  = 8'h3C;
    end
    vecs[0].res = 8'h30; vecs[1].res = 8'hFC; vecs[2].res = 8'h0F; vecs[3].res = 8'hCF;
    vecs[4].res = 8'h03; vecs[5].res = 8'hCC; vecs[6].res = 8'h33; vecs[7].res = 8'h3C;
    vecs[8] = '{op: 3'd5, a: 8'hA5, b: 8'hA5, res: 8'h00, zero: 1'b1, parity: 1'b0};
    vecs[9] = '{op: 3'd7, a: 8'h5A, b: 8'h07, res: 8'h07, zero: 1'b0, parity: 1'b1};
    for (int i = 0; i < 8; i++) begin
      vecs[i].zero   = (vecs[i].res == '0);
      vecs[i].parity = ^vecs[i].res;
    end

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, '0, '0);
    tick(); tick();
    chk("rst_out_valid",  out_valid, 0);
    chk("rst_out_result", out_result, 8'h00);
    chk("rst_out_op",     out_op, 0);
    chk("rst_out_zero",   out_zero, 1);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_in_ready",   in_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // ---------------- streaming table, 2-cycle latency ----------------
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      else        drive(1'b0, 3'd0, '0, '0);
      if (i < 10) chk($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      if (i >= 2) begin
        chk($sformatf("stream_valid_%0d", i-2),  out_valid, 1);
        chk($sformatf("stream_result_%0d", i-2), out_result, vecs[i-2].res);
        chk($sformatf("stream_op_%0d", i-2),     out_op, vecs[i-2].op);
        chk($sformatf("stream_zero_%0d", i-2),   out_zero, vecs[i-2].zero);
        chk($sformatf("stream_parity_%0d", i-2), out_parity, vecs[i-2].parity);
      end else begin
        chk($sformatf("stream_fill_valid_%0d", i), out_valid, 0);
      end
      tick();
    end
    chk("stream_drained", out_valid, 0);

    // ---------------- backpressure: 2 held, 3rd refused ----------------
    r1 = ref_eval(3'd1, 8'h11, 8'h22);
    r2 = ref_eval(3'd3, 8'hFF, 8'h0F);
    r3 = ref_eval(3'd6, 8'h81, 8'h18);
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 8'h11, 8'h22);
    chk("bp_ready_1", in_ready, 1);
    tick();
    drive(1'b1, 3'd3, 8'hFF, 8'h0F);
    chk("bp_ready_2", in_ready, 1);
    tick();
    drive(1'b1, 3'd6, 8'h81, 8'h18);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready_3_refused_%0d", k), in_ready, 0);
      chk_out($sformatf("bp_hold_%0d", k), 3'd1, r1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    chk_out("bp_res1", 3'd1, r1);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    chk_out("bp_res2", 3'd3, r2);
    tick();
    chk_out("bp_res3", 3'd6, r3);
    tick();
    chk("bp_empty", out_valid, 0);

    // ---------------- bubble collapse ----------------
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 8'hCC, 8'hAA);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    tick();
    chk("bub_stalled_valid", out_valid, 1);
    chk("bub_in_ready", in_ready, 1);
    drive(1'b1, 3'd4, 8'h0F, 8'h30);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    chk("bub_full_not_ready", in_ready, 0);
    chk_out("bub_still_first", 3'd0, 8'h88);
    out_ready = 1'b1;
    #1;
    tick();
    chk_out("bub_second", 3'd4, 8'hC0);
    tick();
    chk("bub_empty", out_valid, 0);

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 3'd0, 8'hFF, 8'h0F);
    tick();
    drive(1'b1, 3'd1, 8'h80, 8'h01);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    chk_out("midrst_pre", 3'd0, 8'h0F);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid",  out_valid, 0);
    chk("midrst_result", out_result, 8'h00);
    chk("midrst_zero",   out_zero, 1);
    chk("midrst_op",     out_op, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_no_stale_%0d", k), out_valid, 0);
      tick();
    end
    chk("midrst_ready", in_ready, 1);

    // ---------------- randomized valid/ready vs reference model ----------------
    q.delete();
    accepted   = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    held_res   = '0;
    held_op    = '0;
    held_z     = 1'b0;
    held_p     = 1'b0;
    while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
      if (accepted < 1000)
        drive(($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)),
              W'($urandom), W'($urandom));
      else
        drive(1'b0, 3'd0, '0, '0);
      out_ready = ($urandom_range(0, 99) < 60);
      #1;
      // The unit holds at most two beats; it accepts unless full and stalled.
      chk("rnd_in_ready", in_ready, ((q.size() < 2) || out_ready));
      if (q.size() == 0) chk("rnd_idle_valid", out_valid, 0);
      if (prev_stall) begin
        chk("rnd_stall_valid",  out_valid, 1);
        chk("rnd_stall_result", out_result, held_res);
        chk("rnd_stall_op",     out_op, held_op);
        chk("rnd_stall_zero",   out_zero, held_z);
        chk("rnd_stall_parity", out_parity, held_p);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", out_result, e.res);
          chk("rnd_op",     out_op, e.op);
          chk("rnd_zero",   out_zero, (e.res == '0));
          chk("rnd_parity", out_parity, ^e.res);
        end
      end
      if (in_valid && in_ready) begin
        e.op  = in_op;
        e.res = ref_eval(in_op, in_a, in_b);
        q.push_back(e);
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      held_res   = out_result;
      held_op    = out_op;
      held_z     = out_zero;
      held_p     = out_parity;
      tick();
      cycles++;
    end
    if (cycles >= 20000) chk("rnd_timeout", 1, 0);
    chk("rnd_all_accepted", accepted, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
